// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the pipelined ALU:
//   - MIPS-funct opcode encodings (6 bits) for the eight supported operations
//   - bit positions of the packed status-flag vector
//   - is_legal_opcode(): true for exactly the eight supported encodings
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int OPCODE_BITS = 6;

  localparam logic [OPCODE_BITS-1:0] OP_ADD = 6'b100000;
  localparam logic [OPCODE_BITS-1:0] OP_SUB = 6'b100010;
  localparam logic [OPCODE_BITS-1:0] OP_AND = 6'b100100;
  localparam logic [OPCODE_BITS-1:0] OP_OR  = 6'b100101;
  localparam logic [OPCODE_BITS-1:0] OP_XOR = 6'b100110;
  localparam logic [OPCODE_BITS-1:0] OP_NOR = 6'b100111;
  localparam logic [OPCODE_BITS-1:0] OP_SRA = 6'b000011;
  localparam logic [OPCODE_BITS-1:0] OP_SRL = 6'b000010;

  // Bit positions inside the packed flag vector.
  localparam int FLAG_Z    = 0;
  localparam int FLAG_N    = 1;
  localparam int FLAG_C    = 2;
  localparam int FLAG_V    = 3;
  localparam int NUM_FLAGS = 4;

  function automatic logic is_legal_opcode(input logic [OPCODE_BITS-1:0] op);
    logic legal;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: legal = 1'b1;
      default:                        legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Purely combinational ALU datapath: result, illegal-opcode indication and
// (optionally) status flags for one operand pair.
//
// Optional feature: define ALU_PIPELINE_FLAGS_EN to build the flag logic and
// expose the 'flags' port. Without it the port does not exist.
//
// Ports:
//   a       in  NB_OPERANDO  operand A, shift source for SRA/SRL
//   b       in  NB_OPERANDO  operand B, shift amount for SRA/SRL
//   opcode  in  NB_OPCODE    operation select (encodings in the low 6 bits)
//   result  out NB_OPERANDO  operation result (0 for an illegal opcode)
//   err     out 1            opcode is not one of the eight legal encodings
//   flags   out NUM_FLAGS    {V,C,N,Z} status flags (only with the macro)
// ---------------------------------------------------------------------------
module alu_core
  import alu_pkg::*;
#(
  parameter int NB_OPERANDO = 8,
  parameter int NB_OPCODE   = 6,
  parameter int NB_SHAMT    = $clog2(NB_OPERANDO)
) (
  input  logic [NB_OPERANDO-1:0] a,
  input  logic [NB_OPERANDO-1:0] b,
  input  logic [NB_OPCODE-1:0]   opcode,
  output logic [NB_OPERANDO-1:0] result,
  output logic                   err
`ifdef ALU_PIPELINE_FLAGS_EN
  ,
  output logic [NUM_FLAGS-1:0]   flags
`endif
);

  localparam int MSB = NB_OPERANDO - 1;

  // Any opcode bit above the six encoding bits must be zero for a legal op.
  logic [31:0] op_ext;
  logic        legal;

  assign op_ext = 32'(opcode);
  assign legal  = (op_ext[31:OPCODE_BITS] == '0) && is_legal_opcode(op_ext[OPCODE_BITS-1:0]);
  assign err    = !legal;

  // -------------------------------------------------------------------------
  // Adder / subtractor. With flags enabled the extra top bit carries the
  // carry-out (ADD) or the borrow (SUB).
  // -------------------------------------------------------------------------
  logic [NB_OPERANDO-1:0] add_res;
  logic [NB_OPERANDO-1:0] sub_res;

`ifdef ALU_PIPELINE_FLAGS_EN
  logic [NB_OPERANDO:0] sum_ext;
  logic [NB_OPERANDO:0] diff_ext;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};
  assign add_res  = sum_ext[MSB:0];
  assign sub_res  = diff_ext[MSB:0];
`else
  assign add_res  = a + b;
  assign sub_res  = a - b;
`endif

  // -------------------------------------------------------------------------
  // Shifter. Only the low NB_SHAMT bits of b form the shift amount; any set
  // bit above that saturates the shift (SRL -> 0, SRA -> sign fill), so the
  // result never wraps around to a small shift.
  // -------------------------------------------------------------------------
  logic [NB_SHAMT-1:0]    shamt;
  logic                   shift_over;
  logic signed [MSB:0]    a_signed;
  logic signed [MSB:0]    sra_shifted;
  logic [NB_OPERANDO-1:0] srl_res;
  logic [NB_OPERANDO-1:0] sra_res;

  assign shamt       = b[NB_SHAMT-1:0];
  assign shift_over  = |b[MSB:NB_SHAMT];
  assign a_signed    = $signed(a);
  assign sra_shifted = a_signed >>> shamt;
  assign srl_res     = shift_over ? '0 : (a >> shamt);
  assign sra_res     = shift_over ? {NB_OPERANDO{a[MSB]}} : NB_OPERANDO'(sra_shifted);

  // -------------------------------------------------------------------------
  // Result mux. Illegal opcodes produce 0.
  // -------------------------------------------------------------------------
  always_comb begin
    result = '0;
    if (legal) begin
      case (op_ext[OPCODE_BITS-1:0])
        OP_ADD:  result = add_res;
        OP_SUB:  result = sub_res;
        OP_AND:  result = a & b;
        OP_OR:   result = a | b;
        OP_XOR:  result = a ^ b;
        OP_NOR:  result = ~(a | b);
        OP_SRA:  result = sra_res;
        OP_SRL:  result = srl_res;
        default: result = '0;
      endcase
    end
  end

`ifdef ALU_PIPELINE_FLAGS_EN
  // Z and N follow the result for every opcode (an illegal op yields Z=1,
  // N=0 because its result is 0). C and V are meaningful only for ADD/SUB.
  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_N] = result[MSB];
    if (legal) begin
      case (op_ext[OPCODE_BITS-1:0])
        OP_ADD: begin
          flags[FLAG_C] = sum_ext[NB_OPERANDO];
          flags[FLAG_V] = (a[MSB] == b[MSB]) && (sum_ext[MSB] != a[MSB]);
        end
        OP_SUB: begin
          // C is "no borrow", i.e. a >= b unsigned.
          flags[FLAG_C] = !diff_ext[NB_OPERANDO];
          flags[FLAG_V] = (a[MSB] != b[MSB]) && (diff_ext[MSB] != a[MSB]);
        end
        default: begin
          flags[FLAG_C] = 1'b0;
          flags[FLAG_V] = 1'b0;
        end
      endcase
    end
  end
`endif

endmodule

// File: rtl/alu_pipeline.sv
// ---------------------------------------------------------------------------
// alu_pipeline
// Two-stage registered ALU with valid/ready handshakes on both sides.
//   Stage 1: captures dato_a, dato_b, opcode on an input transfer.
//   Stage 2: registers the alu_core result, err and flags.
// An operand pair accepted on one edge is presented with out_valid after the
// following edge; one result per cycle under continuous valid/ready.
//
// Optional feature: define ALU_PIPELINE_FLAGS_EN to compute and register the
// four status flags. Without it the flag ports are tied to 0.
//
// Ports:
//   clk        in  1            clock, all state on the rising edge
//   reset      in  1            synchronous active-high reset
//   in_valid   in  1            operand triple presented
//   in_ready   out 1            stage 1 can accept this cycle
//   dato_a     in  NB_OPERANDO  operand A / shift source
//   dato_b     in  NB_OPERANDO  operand B / shift amount
//   opcode     in  NB_OPCODE    operation select
//   out_valid  out 1            out, flags and err valid
//   out_ready  in  1            consumer accepts the result
//   out        out NB_OUT       result (NB_OUT must equal NB_OPERANDO)
//   flag_z     out 1            result == 0
//   flag_n     out 1            result MSB
//   flag_c     out 1            ADD carry-out / SUB no-borrow
//   flag_v     out 1            ADD/SUB signed overflow
//   err        out 1            illegal opcode
// ---------------------------------------------------------------------------
module alu_pipeline
  import alu_pkg::*;
#(
  parameter int NB_OPERANDO = 8,
  parameter int NB_OUT      = NB_OPERANDO,
  parameter int NB_OPCODE   = 6,
  parameter int NB_SHAMT    = $clog2(NB_OPERANDO)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NB_OPERANDO-1:0] dato_a,
  input  logic [NB_OPERANDO-1:0] dato_b,
  input  logic [NB_OPCODE-1:0]   opcode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NB_OUT-1:0]      out,
  output logic                   flag_z,
  output logic                   flag_n,
  output logic                   flag_c,
  output logic                   flag_v,
  output logic                   err
);

  // Stage 1 registers
  logic                   s1_valid_reg;
  logic [NB_OPERANDO-1:0] s1_a_reg;
  logic [NB_OPERANDO-1:0] s1_b_reg;
  logic [NB_OPCODE-1:0]   s1_op_reg;

  // Stage 2 registers
  logic                   out_valid_reg;
  logic [NB_OUT-1:0]      out_reg;
  logic                   err_reg;

  // Combinational datapath outputs
  logic [NB_OPERANDO-1:0] result_comb;
  logic                   err_comb;

`ifdef ALU_PIPELINE_FLAGS_EN
  logic [NUM_FLAGS-1:0]   flags_comb;
  logic [NUM_FLAGS-1:0]   flags_reg;
`endif

  // -------------------------------------------------------------------------
  // Handshake. Stage 2 may load whenever it is empty or being drained this
  // cycle; stage 1 may load whenever it is empty or moving into stage 2.
  // in_ready is therefore combinational from out_ready, which is what lets
  // the pipe run without bubbles.
  // -------------------------------------------------------------------------
  logic s2_advance;
  logic in_fire;

  assign s2_advance = !out_valid_reg || out_ready;
  assign in_ready   = !s1_valid_reg || s2_advance;
  assign in_fire    = in_valid && in_ready;

  alu_core #(
    .NB_OPERANDO (NB_OPERANDO),
    .NB_OPCODE   (NB_OPCODE),
    .NB_SHAMT    (NB_SHAMT)
  ) u_core (
    .a      (s1_a_reg),
    .b      (s1_b_reg),
    .opcode (s1_op_reg),
    .result (result_comb),
    .err    (err_comb)
`ifdef ALU_PIPELINE_FLAGS_EN
    ,
    .flags  (flags_comb)
`endif
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
      err_reg       <= 1'b0;
`ifdef ALU_PIPELINE_FLAGS_EN
      flags_reg     <= '0;
`endif
    end else begin
      // Stage 1: when it can accept, its valid follows in_valid; operands
      // are only captured on an actual transfer.
      if (in_ready) begin
        s1_valid_reg <= in_valid;
      end
      if (in_fire) begin
        s1_a_reg  <= dato_a;
        s1_b_reg  <= dato_b;
        s1_op_reg <= opcode;
      end

      // Stage 2: payload is only rewritten when a new result moves in, so
      // held outputs stay stable under back-pressure.
      if (s2_advance) begin
        out_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          out_reg <= result_comb;
          err_reg <= err_comb;
`ifdef ALU_PIPELINE_FLAGS_EN
          flags_reg <= flags_comb;
`endif
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out       = out_reg;
  assign err       = err_reg;

`ifdef ALU_PIPELINE_FLAGS_EN
  assign flag_z = flags_reg[FLAG_Z];
  assign flag_n = flags_reg[FLAG_N];
  assign flag_c = flags_reg[FLAG_C];
  assign flag_v = flags_reg[FLAG_V];
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
  assign flag_c = 1'b0;
  assign flag_v = 1'b0;
`endif

endmodule
